// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: function codes, FSM states
// and op-classification helpers.
package mips_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MADDU = 6'b011101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_listed(input logic [5:0] op);
    case (op)
      OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MADD, OP_MADDU: is_listed = 1'b1;
      default:           is_listed = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD: is_signed_op = 1'b1;
      default:                  is_signed_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] shl_s;
  logic [WIDTH-1:0] diff_s;

  // The remainder is below the divisor, so the subtraction always fits in WIDTH bits
  always_comb begin
    sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shl_s  = {acc_i, 1'b0};
    diff_s = shl_s[2*WIDTH-1:WIDTH] - opnd;
    if (is_div) begin
      if (shl_s[2*WIDTH:WIDTH] >= {1'b0, opnd}) begin
        acc_o = {diff_s, shl_s[WIDTH-1:1], 1'b1};
      end else begin
        acc_o = shl_s[2*WIDTH-1:0];
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS multiply/divide unit: owns Hi/Lo, sequences 32-iteration mul/div,
// handles MTHI/MTLO/MFHI/MFLO and stalls the pipeline while busy.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               is_div_q, is_div_d, is_madd_q, is_madd_d;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d, opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               accept_s, signed_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] iter_acc_s, prod_s, madd_s;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd   (opnd_q),
    .acc_o  (iter_acc_s)
  );

  assign stall  = op_valid & busy_q & is_listed(op);
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = (op == OP_MFHI) ? hi_q : ((op == OP_MFLO) ? lo_q : {WIDTH{1'b0}});

  // Magnitudes of 0x80000000 stay representable as unsigned 2^31
  always_comb begin
    accept_s = op_valid & ~stall & is_listed(op);
    signed_s = is_signed_op(op);
    a_mag_s  = (signed_s & a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_mag_s  = (signed_s & b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    prod_s   = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    madd_s   = {hi_q, lo_q} + prod_s;
    quo_s    = neg_q ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[WIDTH-1:0];
    rem_s    = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    is_madd_d = is_madd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU: begin
              state_d   = CALC;
              busy_d    = 1'b1;
              cnt_d     = {CW{1'b0}};
              is_div_d  = (op == OP_DIV) | (op == OP_DIVU);
              is_madd_d = (op == OP_MADD) | (op == OP_MADDU);
              neg_d     = signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_d = signed_s & a[WIDTH-1];
              div0_d    = (b == {WIDTH{1'b0}});
              a_raw_d   = a;
              opnd_d    = b_mag_s;
              acc_d     = {{WIDTH{1'b0}}, a_mag_s};
            end
            default: begin
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = iter_acc_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          state_d = CALC;
        end
      end
      FIN: begin
        // Divide by zero bypasses sign-fix: Lo all-ones, Hi the raw dividend
        if (is_div_q) begin
          if (div0_q) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_s;
            hi_d = rem_s;
          end
        end else if (is_madd_q) begin
          {hi_d, lo_d} = madd_s;
        end else begin
          {hi_d, lo_d} = prod_s;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      is_madd_q <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= {WIDTH{1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      is_madd_q <= is_madd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      a_raw_q   <= a_raw_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table with a Hi/Lo scoreboard,
// plus hand-written stall and mid-operation reset sequences.
module tb_muldiv_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [5:0]  op = 6'b000000;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        iter;
  } vec_t;

  vec_t vecs[12];

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .stall(stall), .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] o, input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] eh, input logic [31:0] el, input logic it);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.hi = eh; v.lo = el; v.iter = it;
    return v;
  endfunction

  task automatic issue(input logic [5:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic push, input logic [63:0] exp);
    @(negedge clk);
    op = o; a = va; b = vb; op_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Waits for done with a bound, checks busy length, then pops the scoreboard
  task automatic wait_done(input string name);
    int n = 0;
    logic seen = 1'b0;
    logic [63:0] e;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_cycles"}, 32'(n), 32'd33);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_hi"}, hi, e[63:32]);
      chk({name, "_lo"}, lo, e[31:0]);
    end else begin
      chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int bad;
    int dcnt;
    vecs[0]  = mk(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    vecs[1]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    vecs[2]  = mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    vecs[3]  = mk(OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b1);
    vecs[4]  = mk(OP_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    vecs[5]  = mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b1);
    vecs[6]  = mk(OP_MTHI,  32'd0,        32'd0,        32'd0,        32'h80000000, 1'b0);
    vecs[7]  = mk(OP_MTLO,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0);
    vecs[8]  = mk(OP_MADDU, 32'd1,        32'd1,        32'd1,        32'd0,        1'b1);
    vecs[9]  = mk(OP_MADD,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b1);
    vecs[10] = mk(OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
    vecs[11] = mk(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].iter, {vecs[i].hi, vecs[i].lo});
      if (vecs[i].iter) begin
        wait_done(nm);
      end else begin
        @(negedge clk);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_hi"}, hi, vecs[i].hi);
        chk({nm, "_lo"}, lo, vecs[i].lo);
      end
      op = OP_MFHI; op_valid = 1'b1;
      #1 chk({nm, "_mfhi"}, result, vecs[i].hi);
      op = OP_MFLO;
      #1 chk({nm, "_mflo"}, result, vecs[i].lo);
      op_valid = 1'b0;
    end

    // MFLO held during a MULT: stalls until done; MTLO while busy is dropped
    issue(OP_MULT, 32'd6, 32'd7, 1'b1, 64'd42);
    op = OP_MFLO; op_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
      if (op == 6'b000000) chk("stall_unlisted", 32'(stall), 32'd0);
      else if (!stall) bad++;
      if (k == 5) begin op = OP_MTLO; a = 32'hDEADBEEF; end
      else if (k == 10) op = 6'b000000;
      else op = OP_MFLO;
    end
    chk("stall_while_busy_misses", 32'(bad), 32'd0);
    chk("stall_at_done", 32'(stall), 32'd0);
    chk("mflo_at_done", result, 32'd42);
    if (exp_q.size() > 0) chk("stall_seq_lo", lo, exp_q.pop_front()[31:0]);
    else chk("stall_seq_scoreboard", 32'(exp_q.size()), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;

    // Reset during iteration 10 aborts the op with no done pulse
    issue(OP_MULT, 32'd5, 32'd9, 1'b0, 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    issue(OP_MULT, 32'd2, 32'd3, 1'b1, 64'd6);
    wait_done("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
